// File: rtl/hamming_pkg.sv
// hamming_pkg: shared sizing helpers, Hamming position mapping and error classes
package hamming_pkg;

   typedef enum logic [1:0] {CLEAN, SEC, SEC_PBIT, DED} err_class_t;

   function automatic int calc_par_w(input int data_w);
      int r = 0;
      for (int k = 1; k < 32; k++)
         if (r == 0 && (1 << k) >= data_w + k + 1) r = k;
      return r;
   endfunction

   function automatic bit is_pow2(input int p);
      return p != 0 && (p & (p - 1)) == 0;
   endfunction

   // Data bit i lives at the (i+1)-th non-power-of-two position.
   function automatic int data_pos(input int i);
      int n = 0;
      int pos = 0;
      for (int p = 1; p <= i + 33; p++)
         if (pos == 0 && !is_pow2(p)) begin
            if (n == i) pos = p;
            n++;
         end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// hamming_syndrome_calc: syndrome (XOR of set-bit positions) and overall parity of a codeword
module hamming_syndrome_calc #(
   parameter int CW_W  = 8,
   parameter int PAR_W = 3
) (
   input  logic [CW_W-1:0]  cw,
   output logic [PAR_W-1:0] s,
   output logic             q
);

   always_comb begin
      s = '0;
      for (int p = 1; p < CW_W; p++) s = s ^ (cw[p-1] ? PAR_W'(p) : '0);
      q = ^cw;
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: two-stage SECDED decoder with valid/ready flow control
// and saturating single/double error counters.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = calc_par_w(DATA_W),
   localparam int CW_W   = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   input  logic              correct_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [PAR_W:0]    out_err_pos,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sec_count,
   output logic [CNT_W-1:0]  ded_count
);

   localparam logic [PAR_W:0] MAX_POS  = (PAR_W + 1)'(CW_W - 1);
   localparam logic [PAR_W:0] POS_PBIT = (PAR_W + 1)'(CW_W);

   logic [PAR_W-1:0]  syn;
   logic              par;
   logic [DATA_W-1:0] raw_data, dec_data;
   logic              s1_valid_q, s1_valid_d, s1_par_q, s1_par_d, s1_cen_q, s1_cen_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [PAR_W-1:0]  s1_s_q, s1_s_d;
   logic              out_valid_q, out_valid_d, out_sec_q, out_sec_d, out_ded_q, out_ded_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [PAR_W:0]    out_pos_q, out_pos_d;
   logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
   logic              s2_can_load, s1_load, s2_load, xfer, fix_en;
   err_class_t        cls;

   hamming_syndrome_calc #(.CW_W(CW_W), .PAR_W(PAR_W)) u_syn (
      .cw (in_cw),
      .s  (syn),
      .q  (par)
   );

   // Stage 1 keeps only the data bits; stage 2 flips the one addressed by the syndrome.
   for (genvar i = 0; i < DATA_W; i++) begin : g_data
      localparam int P = data_pos(i);
      assign raw_data[i] = in_cw[P-1];
      assign dec_data[i] = s1_data_q[i] ^ (fix_en && s1_s_q == PAR_W'(P));
   end

   assign cls = (s1_s_q == '0) ? (s1_par_q ? SEC_PBIT : CLEAN)
              : (s1_par_q && {1'b0, s1_s_q} <= MAX_POS) ? SEC : DED;
   assign fix_en      = s1_cen_q && cls == SEC;
   assign s2_can_load = !out_valid_q || out_ready;
   assign in_ready    = !s1_valid_q || s2_can_load;
   assign s1_load     = in_valid && in_ready;
   assign s2_load     = s1_valid_q && s2_can_load;
   assign xfer        = out_valid_q && out_ready;

   always_comb begin
      s1_valid_d  = s1_load || (s1_valid_q && !s2_can_load);
      s1_data_d   = s1_load ? raw_data : s1_data_q;
      s1_s_d      = s1_load ? syn : s1_s_q;
      s1_par_d    = s1_load ? par : s1_par_q;
      s1_cen_d    = s1_load ? correct_en : s1_cen_q;
      out_valid_d = s2_can_load ? s1_valid_q : out_valid_q;
      out_data_d  = s2_load ? dec_data : out_data_q;
      out_sec_d   = s2_load ? (cls == SEC || cls == SEC_PBIT) : out_sec_q;
      out_ded_d   = s2_load ? cls == DED : out_ded_q;
      out_pos_d   = !s2_load ? out_pos_q : cls == SEC ? {1'b0, s1_s_q} : cls == SEC_PBIT ? POS_PBIT : '0;
      sec_cnt_d   = cnt_clr ? '0 : (xfer && out_sec_q && sec_cnt_q != '1) ? sec_cnt_q + 1'b1 : sec_cnt_q;
      ded_cnt_d   = cnt_clr ? '0 : (xfer && out_ded_q && ded_cnt_q != '1) ? ded_cnt_q + 1'b1 : ded_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_s_q      <= '0;
         s1_par_q    <= 1'b0;
         s1_cen_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sec_q   <= 1'b0;
         out_ded_q   <= 1'b0;
         out_pos_q   <= '0;
         sec_cnt_q   <= '0;
         ded_cnt_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_s_q      <= s1_s_d;
         s1_par_q    <= s1_par_d;
         s1_cen_q    <= s1_cen_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sec_q   <= out_sec_d;
         out_ded_q   <= out_ded_d;
         out_pos_q   <= out_pos_d;
         sec_cnt_q   <= sec_cnt_d;
         ded_cnt_q   <= ded_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_sec     = out_sec_q;
   assign out_ded     = out_ded_q;
   assign out_err_pos = out_pos_q;
   assign sec_count   = sec_cnt_q;
   assign ded_count   = ded_cnt_q;

endmodule
